// File: rtl/rxn_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rxn_pkg : shared state encoding, LFSR taps and clog2 for the reaction timer
// Rev 1.0
// ---------------------------------------------------------------------------
package rxn_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRERUN = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lfsr16 : free-running 16-bit Galois LFSR (right shift) for the hold-off
// Rev 1.0
// ---------------------------------------------------------------------------
module lfsr16
  import rxn_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        ar,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (ar) q <= SEED;
    else    q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
  end

endmodule
`default_nettype wire

// File: rtl/rxn_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rxn_fsm : multi-player reaction-timer sequencer (hold-off, run, result)
// Rev 1.0
// ---------------------------------------------------------------------------
module rxn_fsm
  import rxn_pkg::*;
#(
  parameter int          N_CH         = 2,
  parameter int          DLY_MIN      = 5000,
  parameter int          DLY_W        = 12,
  parameter int          RAND_EN      = 1,
  parameter int          TIMEOUT      = 10000,
  parameter logic        START_ASSERT = 1'b1,
  parameter logic        STOP_ASSERT  = 1'b1,
  parameter logic [15:0] SEED         = 16'hACE1,
  localparam int         WIN_W        = (N_CH > 1) ? clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             ar,
  input  logic             start,
  input  logic [N_CH-1:0]  stop,
  output logic             ctr_en,
  output logic             ctr_ar,
  output logic             go,
  output logic [WIN_W-1:0] winner,
  output logic             valid,
  output logic             foul,
  output logic             timeout
);

  localparam int DLY_A  = DLY_W + 1;
  localparam int DLY_B  = clog2(DLY_MIN + (1 << DLY_W));
  localparam int DLY_CW = (DLY_A > DLY_B) ? DLY_A : DLY_B;
  localparam int RUN_CW = clog2(TIMEOUT + 1);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic              start_prev;
  logic              start_edge;
  logic              stop_any;
  logic [WIN_W-1:0]  stop_idx;
  logic [DLY_CW-1:0] dly_cnt;
  logic [DLY_CW-1:0] dly_load;
  logic [RUN_CW-1:0] run_cnt;
  logic [15:0]       lfsr;
  logic              unused_lfsr;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk (clk),
    .ar  (ar),
    .q   (lfsr)
  );

  generate
    if (RAND_EN != 0) begin : g_rand
      assign dly_load = DLY_CW'(DLY_MIN) + DLY_CW'(lfsr[DLY_W-1:0]);
    end else begin : g_fixed
      assign dly_load = DLY_CW'(DLY_MIN);
    end
  endgenerate

  // Upper LFSR bits only feed the sequence, not the hold-off addend.
  assign unused_lfsr = ^lfsr;

  assign start_edge = (start == START_ASSERT) && (start_prev != START_ASSERT);
  assign stop_any   = |(~(stop ^ {N_CH{STOP_ASSERT}}));

  // Descending scan so the lowest pressed index is the one left standing.
  always_comb begin
    stop_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (stop[i] == STOP_ASSERT) stop_idx = i[WIN_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (ar) state <= ST_IDLE;
    else    state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start_edge) state_nxt = ST_PRERUN;
      ST_PRERUN: state_nxt = stop_any ? ST_DONE : ST_WAIT;
      ST_WAIT: begin
        if (stop_any)                        state_nxt = ST_DONE;
        else if (dly_cnt <= DLY_CW'(1))      state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (stop_any || (run_cnt == RUN_CW'(TIMEOUT - 1))) state_nxt = ST_DONE;
      end
      ST_DONE:   if (start_edge) state_nxt = ST_PRERUN;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ctr_en = (state == ST_RUN);
    ctr_ar = (state != ST_PRERUN) && !ar;
    go     = ctr_en;
  end

  always_ff @(posedge clk) begin
    if (ar) begin
      start_prev <= ~START_ASSERT;
      dly_cnt    <= '0;
      run_cnt    <= '0;
      winner     <= '0;
      valid      <= 1'b0;
      foul       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      start_prev <= start;
      case (state)
        ST_PRERUN: begin
          dly_cnt <= dly_load;
          run_cnt <= '0;
          valid   <= 1'b0;
          timeout <= 1'b0;
          foul    <= stop_any;
          winner  <= stop_any ? stop_idx : '0;
        end
        ST_WAIT: begin
          if (dly_cnt != '0) dly_cnt <= dly_cnt - DLY_CW'(1);
          if (stop_any) begin
            foul   <= 1'b1;
            winner <= stop_idx;
          end
        end
        ST_RUN: begin
          if (run_cnt != '1) run_cnt <= run_cnt + RUN_CW'(1);
          if (stop_any) begin
            valid  <= 1'b1;
            winner <= stop_idx;
          end else if (run_cnt == RUN_CW'(TIMEOUT - 1)) begin
            timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
